// File: rtl/sd_secbuf_if.sv
// Stream-in / read-port bundle for sd_sector_buffer.
// The buffer uses the slave modport; the upstream reader and consumer side use master.
interface sd_secbuf_if;
  logic [7:0]  InData;
  logic        InEnable;
  logic [23:0] NextAddress;
  logic        RdEn;
  logic        RdReady;
  logic [7:0]  RdData;
  logic        RdValid;
  logic [1:0]  BankFull;
  logic        Overrun;
  logic        ShortFrame;
  logic        ClearFlags;
  logic [7:0]  SectorChecksum;

  modport slave (
    input  InData, InEnable, RdEn, ClearFlags,
    output NextAddress, RdReady, RdData, RdValid, BankFull, Overrun, ShortFrame,
           SectorChecksum
  );

  modport master (
    output InData, InEnable, RdEn, ClearFlags,
    input  NextAddress, RdReady, RdData, RdValid, BankFull, Overrun, ShortFrame,
           SectorChecksum
  );
endinterface

// File: rtl/sd_sector_buffer.sv
// Double-buffered capture of SD CMD17 data windows with a request/strobe read port.
// Optional per-sector XOR checksum: define SD_SECBUF_CHECKSUM_EN.
//   state | meaning
//   IDLE  | waiting for a rising InEnable
//   FILL  | storing sector bytes into the write bank
//   SKIP  | sector committed; discarding CRC/trailing bytes
//   DROP  | write bank still full; discarding the whole window
module sd_sector_buffer #(
  parameter logic [23:0] StartAddress = 24'h000000,
  parameter logic [23:0] AddressStep  = 24'd2,
  parameter int          SectorBytes  = 512
) (
  input logic        DataClock,
  input logic        Reset,
  sd_secbuf_if.slave bus
);
  localparam int CW = $clog2(SectorBytes);
  localparam logic [CW-1:0] LastOff = CW'(SectorBytes - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {IDLE, FILL, SKIP, DROP} wr_state_e;

  wr_state_e   state_q, state_d;
  logic        en_prev_q;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]  full_q, full_d;
  logic [23:0] addr_q, addr_d;
  logic        ovr_q, ovr_d, short_q, short_d;
  logic        rd_acc_q, rd_valid_q;
  logic [CW:0] rd_ptr_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  mem_q [2*SectorBytes];

  logic        mem_we, commit, ovr_set, short_set;
  logic [CW-1:0] mem_woff;
  logic        rd_ready, rd_acc, rd_last;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    mem_we    = 1'b0;
    mem_woff  = wcnt_q;
    commit    = 1'b0;
    ovr_set   = 1'b0;
    short_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.InEnable && !en_prev_q) begin
          if (full_q[wr_q]) begin
            state_d = DROP;
            ovr_set = 1'b1;
          end else begin
            state_d  = FILL;
            mem_we   = 1'b1;
            mem_woff = '0;
            wcnt_d   = CntOne;
          end
        end
      end
      FILL: begin
        if (bus.InEnable) begin
          mem_we = 1'b1;
          if (wcnt_q == LastOff) begin
            commit  = 1'b1;
            wr_d    = ~wr_q;
            addr_d  = addr_q + AddressStep;
            wcnt_d  = '0;
            state_d = SKIP;
          end else begin
            wcnt_d = wcnt_q + CntOne;
          end
        end else begin
          short_set = 1'b1;
          wcnt_d    = '0;
          state_d   = IDLE;
        end
      end
      SKIP, DROP: begin
        if (!bus.InEnable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit and release always target different banks, so both may apply at once.
  always_comb begin
    rd_ready = full_q[rd_q];
    rd_acc   = bus.RdEn && rd_ready;
    rd_last  = rd_acc && (rcnt_q == LastOff);
    rcnt_d   = rcnt_q;
    rd_d     = rd_q;
    if (rd_acc) rcnt_d = rd_last ? '0 : rcnt_q + CntOne;
    if (rd_last) rd_d = ~rd_q;
    full_d = full_q;
    if (commit) full_d[wr_q] = 1'b1;
    if (rd_last) full_d[rd_q] = 1'b0;
    ovr_d   = (ovr_q & ~bus.ClearFlags) | ovr_set;
    short_d = (short_q & ~bus.ClearFlags) | short_set;
  end

  always_ff @(posedge DataClock) begin
    if (Reset) begin
      state_q    <= IDLE;
      en_prev_q  <= 1'b1;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      full_q     <= '0;
      addr_q     <= StartAddress;
      ovr_q      <= 1'b0;
      short_q    <= 1'b0;
      rd_acc_q   <= 1'b0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= bus.InEnable;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      full_q     <= full_d;
      addr_q     <= addr_d;
      ovr_q      <= ovr_d;
      short_q    <= short_d;
      rd_acc_q   <= rd_acc;
      rd_ptr_q   <= {rd_q, rcnt_q};
      rd_valid_q <= rd_acc_q;
      if (rd_acc_q) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge DataClock) begin
    if (mem_we) mem_q[{wr_q, mem_woff}] <= bus.InData;
  end

`ifdef SD_SECBUF_CHECKSUM_EN
  logic [7:0] csum_run_q, csum_run_d, csum_q, csum_d;
  logic       win_start;

  assign win_start = mem_we && (state_q == IDLE);

  always_comb begin
    csum_run_d = csum_run_q;
    if (win_start) csum_run_d = bus.InData;
    else if (mem_we) csum_run_d = csum_run_q ^ bus.InData;
    csum_d = commit ? (csum_run_q ^ bus.InData) : csum_q;
  end

  always_ff @(posedge DataClock) begin
    if (Reset) begin
      csum_run_q <= '0;
      csum_q     <= '0;
    end else begin
      csum_run_q <= csum_run_d;
      csum_q     <= csum_d;
    end
  end

  assign bus.SectorChecksum = csum_q;
`else
  assign bus.SectorChecksum = 8'h00;
`endif

  assign bus.NextAddress = addr_q;
  assign bus.RdReady     = rd_ready;
  assign bus.RdData      = rd_data_q;
  assign bus.RdValid     = rd_valid_q;
  assign bus.BankFull    = full_q;
  assign bus.Overrun     = ovr_q;
  assign bus.ShortFrame  = short_q;
endmodule

// File: doc/sd_sector_buffer.md
# sd_sector_buffer

Double-buffered sink for the SD SPI reader's data stream. Captures each 512-byte CMD17 data window (byte stream qualified by `EnableDataRead`) into one of two on-chip banks and generates the next block address for the reader. It presents completed sectors to the audio/video consumer through a request/strobe read port. The block sits directly downstream of the SD SPI controller, in its `DataClock` domain.

## Interface
- `StartAddress`, 24'h000000: first value of `NextAddress` after reset.
- `AddressStep`, 2: increment applied to `NextAddress` per committed sector. The command argument is {addr,8'h00}, so 2 equals 512 bytes.
- `SectorBytes`, 512: bytes per sector; must be a power of two.

Ports:
- `DataClock` in 1: byte clock from the SD SPI controller; all logic on its rising edge.
- `Reset` in 1: synchronous, active-high; clock `DataClock`.
- `InData` in 8: received byte (`InputData`).
- `InEnable` in 1: data window qualifier (`EnableDataRead`).
- `NextAddress` out 24: block address for the reader's next CMD17 (`InputAddress`).
- `RdEn` in 1: consumer byte request; ignored unless `RdReady`.
- `RdReady` out 1: a full bank is available to read.
- `RdData` out 8: read byte, valid when `RdValid`.
- `RdValid` out 1: one-cycle strobe, one cycle after an accepted `RdEn`.
- `BankFull` out 2: per-bank full flags.
- `Overrun` out 1: sticky; a window arrived while the write bank was full.
- `ShortFrame` out 1: sticky; a window ended before `SectorBytes` bytes arrived.
- `ClearFlags` in 1: clears `Overrun` and `ShortFrame`.
- `SectorChecksum` out 8: see Configuration.

## Operation
- Reset values: `NextAddress`=`StartAddress`, `RdReady`=0, `RdData`=0, `RdValid`=0, `BankFull`=0, `Overrun`=0, `ShortFrame`=0, `SectorChecksum`=0. Write and read bank pointers reset to 0, byte counters to 0, FSM to IDLE. RAM contents are don't-care.
- Write FSM states:
  - IDLE: on the first cycle with `InEnable`=1 and a registered previous `InEnable`=0:
    - If `BankFull[wr]`=1: go to DROP and set `Overrun`.
    - Else: go to FILL and store that cycle's `InData` at offset 0.
  - FILL: each cycle with `InEnable`=1 stores `InData` at the counter offset and increments the counter.
    - When the byte at offset `SectorBytes`-1 is stored: commit. Set `BankFull[wr]`, toggle `wr`, `NextAddress += AddressStep` (mod 2^24, wraps to 0), go to SKIP.
    - If `InEnable` falls first: set `ShortFrame`, no commit, address unchanged, go to IDLE.
  - SKIP: discard bytes (CRC, trailing) until `InEnable`=0, then go to IDLE.
  - DROP: discard the whole window until `InEnable`=0, then go to IDLE. The address is not advanced, so the same sector is re-read.
- Read side:
  - `RdReady` = `BankFull[rd]`. An accepted `RdEn` reads RAM[rd][rdcnt] synchronously and increments `rdcnt`.
  - On acceptance of offset `SectorBytes`-1: clear `BankFull[rd]`, toggle `rd`, reset `rdcnt`.
- Simultaneous commit and release in one cycle: both take effect; they act on different banks.
- `ClearFlags` in the same cycle as a flag-setting event: set wins.
- Reset mid-window: immediate return to IDLE. The remainder of the current window is treated as a new rising edge only if `InEnable` is first seen low.

## Timing
- Write latency: the final byte sampled at edge N → `BankFull` bit and `NextAddress` update visible after edge N.
- Read: `RdEn`·`RdReady` at edge N → `RdData`/`RdValid` after edge N+1 (one-cycle latency). Back-to-back `RdEn` gives 1 byte/cycle.
- After the last accepted `RdEn` of a bank: `RdReady` reflects the other bank from the next cycle.
- The upstream controller latches `NextAddress` at its window start. The value committed by window k is therefore used by read k+2; the reader tolerates this one-sector pipeline lag.

## Configuration
- `SD_SECBUF_CHECKSUM_EN` defined:
  - A running XOR of bytes stored in FILL, cleared at window start.
  - On commit, `SectorChecksum` is loaded with the final XOR and holds until the next commit.
- Undefined: no checksum logic; `SectorChecksum` is tied to 8'h00.

## Test plan
- Reset, then one 512-byte window of bytes i[7:0] + 2 trailing bytes → `BankFull`=01, `NextAddress`=2; 512 `RdEn` return 0x00..0xFF twice; `BankFull`=00. With the macro, `SectorChecksum`=0x00.
- Three windows with no reads → banks 0 and 1 full, third window sets `Overrun`=1, `NextAddress`=4 (not 6).
- Window dropped after 100 bytes → `ShortFrame`=1, `BankFull` unchanged, `NextAddress` unchanged. `ClearFlags` then clears the flag.
- Continuous `RdEn` while the second window commits → commit and release in the same cycle; no byte lost; `RdValid` continuous across the bank switch.
- `StartAddress`=24'hFFFFFE, one window → `NextAddress`=24'h000000.
- `Reset` asserted at byte 300 of a window → all outputs return to reset values. The next full window commits to bank 0.
